// File: rtl/l2_noc_out_packer_pkg.sv
// Shared L2 NoC-out types: message bundles, head flit layout,
// preamble codes and packer state encoding.
package l2_noc_out_packer_pkg;

  localparam int BITS_PER_WORD = 64;
  localparam int N_WORDS       = 4;
  localparam int TILE_BITS     = 4;
  localparam int LINE_ADDR_W   = 26;
  localparam int COH_MSG_W     = 5;
  localparam int HPROT_W       = 2;

  localparam logic [1:0] PRE_HEAD = 2'b10;
  localparam logic [1:0] PRE_BODY = 2'b00;
  localparam logic [1:0] PRE_TAIL = 2'b01;

  localparam logic MSG_REQ = 1'b0;
  localparam logic MSG_RSP = 1'b1;

  typedef logic [COH_MSG_W-1:0]   coh_msg_t;
  typedef logic [HPROT_W-1:0]     hprot_t;
  typedef logic [LINE_ADDR_W-1:0] line_addr_t;
  typedef logic [N_WORDS-1:0]     word_mask_t;
  typedef logic [TILE_BITS-1:0]   tile_id_t;
  typedef logic [N_WORDS-1:0][BITS_PER_WORD-1:0] line_t;

  localparam coh_msg_t REQ_GETS      = 5'd0;
  localparam coh_msg_t REQ_GETM      = 5'd1;
  localparam coh_msg_t REQ_PUTS      = 5'd2;
  localparam coh_msg_t REQ_PUTM      = 5'd3;
  localparam coh_msg_t REQ_WT        = 5'd4;
  localparam coh_msg_t RSP_INV_ACK   = 5'd0;
  localparam coh_msg_t RSP_DATA      = 5'd1;
  localparam coh_msg_t RSP_DATA_XFER = 5'd2;
  localparam coh_msg_t RSP_ACK       = 5'd3;

  typedef struct packed {
    coh_msg_t   coh_msg;
    hprot_t     hprot;
    line_addr_t addr;
    line_t      line;
    word_mask_t word_mask;
  } l2_req_out_t;

  typedef struct packed {
    coh_msg_t   coh_msg;
    tile_id_t   req_id;
    logic       to_req;
    line_addr_t addr;
    line_t      line;
    word_mask_t word_mask;
  } l2_rsp_out_t;

  // Declared MSB first so coh_msg lands in the low bits of the flit.
  typedef struct packed {
    logic       msg_class;
    tile_id_t   dst;
    tile_id_t   src;
    word_mask_t word_mask;
    coh_msg_t   coh_msg;
  } noc_head_t;

  typedef enum logic [1:0] {
    IDLE,
    HEAD,
    ADDR,
    DATA
  } packer_state_t;

  function automatic logic msg_has_data(
    input logic     msg_class,
    input coh_msg_t coh_msg
  );
    logic d;
    d = 1'b0;
    unique case (1'b1)
      msg_class == MSG_RSP:
        d = (coh_msg == RSP_DATA) || (coh_msg == RSP_DATA_XFER);
      default:
        d = (coh_msg == REQ_PUTM) || (coh_msg == REQ_WT);
    endcase
    return d;
  endfunction

endpackage

// File: rtl/l2_noc_head_gen.sv
// Builds the head flit fields from the latched message,
// including destination selection (requester or home LLC).
module l2_noc_head_gen
  import l2_noc_out_packer_pkg::*;
#(
  parameter int LLC_BITS = 2
) (
  input  logic                msg_class,
  input  coh_msg_t            coh_msg,
  input  word_mask_t          word_mask,
  input  tile_id_t            src,
  input  tile_id_t            req_id,
  input  logic                to_req,
  input  logic [LLC_BITS-1:0] llc_sel,
  input  tile_id_t            llc_base_id,
  output noc_head_t           head
);

  tile_id_t home;

  assign home = llc_base_id + tile_id_t'(llc_sel);

  always_comb begin
    head           = '0;
    head.coh_msg   = coh_msg;
    head.word_mask = word_mask;
    head.src       = src;
    head.msg_class = msg_class;
    unique case (1'b1)
      msg_class && to_req: head.dst = req_id;
      default:             head.dst = home;
    endcase
  end

endmodule

// File: rtl/l2_noc_out_packer.sv
// Arbitrates L2 rsp/req out channels (rsp first) and serializes
// each message into an atomic head/addr/data flit packet.
module l2_noc_out_packer
  import l2_noc_out_packer_pkg::*;
#(
  parameter int NOC_W          = BITS_PER_WORD,
  parameter int WORDS_PER_LINE = N_WORDS,
  parameter int TILE_ID_W      = TILE_BITS,
  parameter int LLC_BITS       = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [TILE_ID_W-1:0] my_tile_id,
  input  logic [TILE_ID_W-1:0] llc_base_id,
  input  logic                 l2_req_out_valid,
  output logic                 l2_req_out_ready,
  input  l2_req_out_t          l2_req_out,
  input  logic                 l2_rsp_out_valid,
  output logic                 l2_rsp_out_ready,
  input  l2_rsp_out_t          l2_rsp_out,
  output logic                 noc_out_valid,
  input  logic                 noc_out_ready,
  output logic [NOC_W+1:0]     noc_out_data
);

  localparam int CNT_W = $clog2(WORDS_PER_LINE);
  localparam int PAD_W = NOC_W - $bits(noc_head_t);

  packer_state_t    state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             cls_q;
  logic             to_req_q;
  coh_msg_t         coh_q;
  word_mask_t       mask_q;
  line_addr_t       addr_q;
  line_t            line_q;
  tile_id_t         req_id_q;

  noc_head_t head;
  logic      has_data;
  logic      last_word;
  logic      is_tail;
  logic      fire;
  logic      can_accept;
  logic      take_rsp;
  logic      take_req;
  logic      unused_hprot;

  assign unused_hprot = ^l2_req_out.hprot;

  l2_noc_head_gen #(
    .LLC_BITS (LLC_BITS)
  ) u_head_gen (
    .msg_class   (cls_q),
    .coh_msg     (coh_q),
    .word_mask   (mask_q),
    .src         (my_tile_id),
    .req_id      (req_id_q),
    .to_req      (to_req_q),
    .llc_sel     (addr_q[LLC_BITS-1:0]),
    .llc_base_id (llc_base_id),
    .head        (head)
  );

  assign has_data  = msg_has_data(cls_q, coh_q);
  assign last_word = cnt_q == CNT_W'(WORDS_PER_LINE - 1);
  assign is_tail   = ((state_q == ADDR) && !has_data) ||
                     ((state_q == DATA) && last_word);

  assign noc_out_valid = state_q != IDLE;
  assign fire          = noc_out_valid && noc_out_ready;
  assign can_accept    = (state_q == IDLE) || (fire && is_tail);

  assign l2_rsp_out_ready = can_accept;
  assign l2_req_out_ready = can_accept && !l2_rsp_out_valid;

  assign take_rsp = can_accept && l2_rsp_out_valid;
  assign take_req = l2_req_out_ready && l2_req_out_valid;

  always_comb begin
    noc_out_data = '0;
    unique case (state_q)
      HEAD: noc_out_data = {PRE_HEAD, {PAD_W{1'b0}}, head};
      ADDR: noc_out_data = {is_tail ? PRE_TAIL : PRE_BODY,
                            NOC_W'(addr_q)};
      DATA: noc_out_data = {is_tail ? PRE_TAIL : PRE_BODY,
                            line_q[cnt_q]};
      default: noc_out_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cls_q    <= MSG_REQ;
      to_req_q <= 1'b0;
      coh_q    <= '0;
      mask_q   <= '0;
      addr_q   <= '0;
      line_q   <= '0;
      req_id_q <= '0;
    end else begin
      if (take_rsp || take_req) begin
        state_q <= HEAD;
        if (take_rsp) begin
          cls_q    <= MSG_RSP;
          to_req_q <= l2_rsp_out.to_req;
          req_id_q <= l2_rsp_out.req_id;
          coh_q    <= l2_rsp_out.coh_msg;
          mask_q   <= l2_rsp_out.word_mask;
          addr_q   <= l2_rsp_out.addr;
          line_q   <= l2_rsp_out.line;
        end else begin
          cls_q    <= MSG_REQ;
          to_req_q <= 1'b0;
          req_id_q <= '0;
          coh_q    <= l2_req_out.coh_msg;
          mask_q   <= l2_req_out.word_mask;
          addr_q   <= l2_req_out.addr;
          line_q   <= l2_req_out.line;
        end
      end else begin
        unique case (state_q)
          HEAD: if (fire) state_q <= ADDR;
          ADDR: if (fire) state_q <= has_data ? DATA : IDLE;
          DATA: if (fire && last_word) state_q <= IDLE;
          default: ;
        endcase
      end
      if (state_q == ADDR)
        cnt_q <= '0;
      else if ((state_q == DATA) && fire)
        cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule
